// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter onto a byte-wide data memory.
// Each accepted request runs 1, 2 or 4 byte beats and then one response cycle.
module dmem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [1:0]        p0_size,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ready,
    output logic              p0_resp,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [1:0]        p1_size,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ready,
    output logic              p1_resp,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t            state_q;
    logic              owner_q;
    logic              prio_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_q;

    logic              gnt0_d;
    logic              gnt1_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [1:0]        sel_size_d;
    logic [31:0]       sel_wdata_d;
    logic              in_beat;
    logic              in_resp;

    // prio_q names the port that wins when both request together
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (p0_valid && (!p1_valid || !prio_q)) begin
                gnt0_d = 1'b1;
            end else if (p1_valid) begin
                gnt1_d = 1'b1;
            end
        end
    end

    assign sel_we_d    = gnt1_d ? p1_we    : p0_we;
    assign sel_addr_d  = gnt1_d ? p1_addr  : p0_addr;
    assign sel_size_d  = gnt1_d ? p1_size  : p0_size;
    assign sel_wdata_d = gnt1_d ? p1_wdata : p0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            beat_q  <= '0;
            last_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt0_d || gnt1_d) begin
                        owner_q <= gnt1_d;
                        prio_q  <= gnt0_d;
                        we_q    <= sel_we_d;
                        addr_q  <= sel_addr_d;
                        wdata_q <= sel_wdata_d;
                        rdata_q <= '0;
                        beat_q  <= '0;
                        // last beat index: byte 0, half 1, word 3
                        last_q  <= {sel_size_d[1], |sel_size_d};
                        err_q   <= (sel_size_d == 2'b11);
                        state_q <= (sel_size_d == 2'b11) ? RESP : BEAT;
                    end
                end
                BEAT: begin
                    if (!we_q) begin
                        rdata_q[{beat_q, 3'b000} +: 8] <= mem_rdata;
                    end
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == last_q) begin
                        state_q <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with reset keeps an aborted beat from writing memory
    assign in_beat = (state_q == BEAT) && !reset;
    assign in_resp = (state_q == RESP) && !reset;

    assign mem_we    = in_beat && we_q;
    assign mem_addr  = in_beat ? addr_q + ADDR_W'(beat_q) : '0;
    assign mem_wdata = in_beat ? wdata_q[{beat_q, 3'b000} +: 8] : '0;
    assign busy      = (state_q != IDLE) && !reset;

    assign p0_ready = gnt0_d;
    assign p1_ready = gnt1_d;
    assign p0_resp  = in_resp && !owner_q;
    assign p1_resp  = in_resp && owner_q;
    assign p0_rdata = p0_resp ? rdata_q : '0;
    assign p1_rdata = p1_resp ? rdata_q : '0;
    assign p0_err   = p0_resp && err_q;
    assign p1_err   = p1_resp && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-byte memory model.
// Vector table for single transactions plus arbitration and reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_we, p0_ready, p0_resp, p0_err;
    logic [4:0]  p0_addr;
    logic [1:0]  p0_size;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_valid, p1_we, p1_ready, p1_resp, p1_err;
    logic [4:0]  p1_addr;
    logic [1:0]  p1_size;
    logic [31:0] p1_wdata, p1_rdata;
    logic        mem_we, busy;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [32];
    logic        tb_clr;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_size(p0_size), .p0_wdata(p0_wdata), .p0_ready(p0_ready),
        .p0_resp(p0_resp), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_size(p1_size), .p1_wdata(p1_wdata), .p1_ready(p1_ready),
        .p1_resp(p1_resp), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct {
        bit          port;
        bit          we;
        logic [4:0]  addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit v, input bit we,
                         input logic [4:0] a, input logic [1:0] s,
                         input logic [31:0] d);
        if (port) begin
            p1_valid = v; p1_we = we; p1_addr = a; p1_size = s; p1_wdata = d;
        end else begin
            p0_valid = v; p0_we = we; p0_addr = a; p0_size = s; p0_wdata = d;
        end
    endtask

    task automatic run(input vec_t v);
        logic [7:0] b;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        drive(v.port, 1'b1, v.we, v.addr, v.size, v.wdata);
        #1;
        chk("ready", {30'd0, p1_ready, p0_ready}, v.port ? 32'd2 : 32'd1);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        // scramble the port inputs; the latched request must not change
        drive(v.port, 1'b0, ~v.we, v.addr + 5'd13, 2'b00, ~v.wdata);
        for (int i = 0; i < v.n; i++) begin
            #1;
            chk("beat_we", mem_we, v.we);
            chk("beat_addr", mem_addr, 32'(5'(v.addr + 5'(i))));
            if (v.we) chk("beat_wdata", mem_wdata, v.wdata[8*i +: 8]);
            chk("beat_busy", busy, 1);
            chk("beat_ready", {p1_ready, p0_ready}, 0);
            @(negedge clk);
        end
        #1;
        chk("resp", {30'd0, p1_resp, p0_resp}, v.port ? 32'd2 : 32'd1);
        chk("resp_rdata", v.port ? p1_rdata : p0_rdata, v.exp_rdata);
        chk("resp_err", v.port ? p1_err : p0_err, v.exp_err);
        chk("other_rdata", v.port ? p0_rdata : p1_rdata, 0);
        chk("other_err", v.port ? p0_err : p1_err, 0);
        chk("resp_mem_we", mem_we, 0);
        chk("resp_mem_addr", mem_addr, 0);
        @(negedge clk);
        #1;
        chk("idle_after", busy, 0);
        if (v.we) begin
            for (int i = 0; i < v.n; i++) begin
                b = mem[5'(v.addr + 5'(i))];
                chk("mem_content", b, v.wdata[8*i +: 8]);
            end
        end
        @(negedge clk);
    endtask

    vec_t tbl [10];
    int   k;
    int   c0;
    int   c1;

    initial begin
        tbl[0] = '{0, 1, 5'd4,  2'b10, 32'hDDCCBBAA, 32'h0,        0, 4};
        tbl[1] = '{1, 1, 5'd30, 2'b10, 32'h44332211, 32'h0,        0, 4};
        tbl[2] = '{1, 0, 5'd30, 2'b10, 32'h0,        32'h44332211, 0, 4};
        tbl[3] = '{0, 0, 5'd4,  2'b10, 32'h0,        32'hDDCCBBAA, 0, 4};
        tbl[4] = '{1, 1, 5'd2,  2'b01, 32'h1234A55A, 32'h0,        0, 2};
        tbl[5] = '{0, 0, 5'd2,  2'b01, 32'h0,        32'h0000A55A, 0, 2};
        tbl[6] = '{0, 1, 5'd31, 2'b00, 32'hFFFFFF77, 32'h0,        0, 1};
        tbl[7] = '{1, 0, 5'd31, 2'b00, 32'h0,        32'h00000077, 0, 1};
        tbl[8] = '{0, 1, 5'd0,  2'b11, 32'hFFFFFFFF, 32'h0,        1, 0};
        tbl[9] = '{1, 0, 5'd0,  2'b00, 32'h0,        32'h00000033, 0, 1};

        reset = 1'b1;
        tb_clr = 1'b1;
        drive(0, 1'b1, 1'b0, 5'd0, 2'b00, 32'h0);
        drive(1, 1'b1, 1'b0, 5'd1, 2'b00, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {p1_ready, p0_ready}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_resp", {p1_resp, p0_resp}, 0);
        @(negedge clk);
        reset = 1'b0;
        tb_clr = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wdata", mem_wdata, 0);
        chk("post_rst_rdata", p0_rdata | p1_rdata, 0);
        chk("post_rst_err", {p1_err, p0_err}, 0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run(tbl[i]);

        // round robin from reset: expect p0,p1,p0,p1,p0,p1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        c0 = 3;
        c1 = 3;
        for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
            drive(0, c0 > 0, 1'b0, 5'd4, 2'b00, 32'h0);
            drive(1, c1 > 0, 1'b0, 5'd5, 2'b00, 32'h0);
            #1;
            if (p0_ready || p1_ready) begin
                chk("rr_grant", {30'd0, p1_ready, p0_ready},
                    (k % 2 == 1) ? 32'd2 : 32'd1);
                if (p0_ready) c0--;
                if (p1_ready) c1--;
                k++;
            end
            @(negedge clk);
        end
        chk("rr_count", k, 6);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // reset at the second beat of a word store to address 8
        drive(0, 1'b1, 1'b1, 5'd8, 2'b10, 32'h44332211);
        #1;
        chk("abort_ready", p0_ready, 1);
        @(negedge clk);
        p0_valid = 1'b0;
        #1;
        chk("abort_beat0_we", mem_we, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_we_gated", mem_we, 0);
        chk("abort_no_resp", p0_resp, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_resp", {p1_resp, p0_resp}, 0);
        chk("abort_mem8", mem[8], 8'h11);
        chk("abort_mem9", mem[9], 8'h00);
        chk("abort_mem10", mem[10], 8'h00);
        drive(0, 1'b1, 1'b0, 5'd8, 2'b00, 32'h0);
        drive(1, 1'b1, 1'b0, 5'd9, 2'b00, 32'h0);
        #1;
        chk("abort_regrant", {30'd0, p1_ready, p0_ready}, 32'd1);
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
